mul_seq_ctrl: RTL and testbench

Sequencing controller for an iterative shift-add multiplier in the execute stage of the pipelined ARM core. It accepts MUL/MLA operands from EX and holds the pipeline while the product is computed. It freezes Fetch, Decode and Execute and injects bubbles into Memory during the computation, then releases the pipeline in the cycle the result is valid on the EX result path. Its stall and flush outputs are ORed with the hazard unit's StallF/StallD/FlushE-side controls at the top level.

---
 rtl/mul_seq_ctrl.sv | 114 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for an iterative shift-add MUL/MLA unit in EX; holds F/D/E and bubbles M while iterating.
// Optional MUL_SEQ_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_seq_ctrl #(
  parameter int unsigned RADIX_BITS = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic        MlaE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic [31:0] AccE,
  output logic        StallF,
  output logic        StallD,
  output logic        StallE,
  output logic        FlushM,
  output logic        BusyE,
  output logic        MulDoneE,
  output logic [31:0] MulResultE
);

  localparam int unsigned N  = 32 / RADIX_BITS;
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state, stateNext;
  logic [31:0]   mcand, mplier, product, resultReg;
  logic [31:0]   partial, mcandNext, mplierNext;
  logic [CW-1:0] count;
  logic          holdPipe;

  assign mcandNext  = mcand << RADIX_BITS;
  assign mplierNext = mplier >> RADIX_BITS;

  generate
    if (RADIX_BITS == 2) begin : gRadix2
      // Digit 3 uses mcand + 2*mcand formed in the same cycle.
      always_comb begin
        partial = '0;
        unique case (mplier[1:0])
          2'd0: partial = '0;
          2'd1: partial = mcand;
          2'd2: partial = mcand << 1;
          2'd3: partial = mcand + (mcand << 1);
          default: partial = '0;
        endcase
      end
    end else begin : gRadix1
      assign partial = mplier[0] ? mcand : '0;
    end
  endgenerate

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE: if (StartE) stateNext = RUN;
      RUN: begin
        if (count == CW'(N - 1)) stateNext = DONE;
`ifdef MUL_SEQ_EARLY_TERM_EN
        else if (mplierNext == '0) stateNext = DONE;
`endif
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      count     <= '0;
      product   <= '0;
      resultReg <= '0;
      mcand     <= '0;
      mplier    <= '0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (StartE) begin
            mcand   <= SrcAE;
            mplier  <= SrcBE;
            product <= MlaE ? AccE : '0;
            count   <= '0;
          end
        end
        RUN: begin
          product <= product + partial;
          mcand   <= mcandNext;
          mplier  <= mplierNext;
          count   <= count + CW'(1);
        end
        DONE: resultReg <= product;
        default: ;
      endcase
    end
  end

  // Stall in the accepting cycle too, so the MUL stays in E from its first cycle.
  assign holdPipe   = (state == RUN) || ((state == IDLE) && StartE);
  assign StallF     = holdPipe;
  assign StallD     = holdPipe;
  assign StallE     = holdPipe;
  assign FlushM     = holdPipe;
  assign BusyE      = (state != IDLE);
  assign MulDoneE   = (state == DONE);
  assign MulResultE = (state == DONE) ? product : resultReg;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: one radix-1 and one radix-2 instance, checked cycle by cycle.
module tb_mul_seq_ctrl;

`ifdef MUL_SEQ_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        StartE1 = 1'b0, StartE2 = 1'b0;
  logic        MlaE = 1'b0;
  logic [31:0] SrcAE = '0, SrcBE = '0, AccE = '0;

  logic        StallF1, StallD1, StallE1, FlushM1, BusyE1, MulDoneE1;
  logic        StallF2, StallD2, StallE2, FlushM2, BusyE2, MulDoneE2;
  logic [31:0] MulResultE1, MulResultE2;

  logic        useR2 = 1'b0;
  logic [3:0]  selStall;
  logic        selBusy, selDone;
  logic [31:0] selResult;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.RADIX_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .StartE(StartE1), .MlaE(MlaE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .AccE(AccE),
    .StallF(StallF1), .StallD(StallD1), .StallE(StallE1), .FlushM(FlushM1),
    .BusyE(BusyE1), .MulDoneE(MulDoneE1), .MulResultE(MulResultE1)
  );

  mul_seq_ctrl #(.RADIX_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .StartE(StartE2), .MlaE(MlaE),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .AccE(AccE),
    .StallF(StallF2), .StallD(StallD2), .StallE(StallE2), .FlushM(FlushM2),
    .BusyE(BusyE2), .MulDoneE(MulDoneE2), .MulResultE(MulResultE2)
  );

  always_comb begin
    if (useR2) begin
      selStall  = {StallF2, StallD2, StallE2, FlushM2};
      selBusy   = BusyE2;
      selDone   = MulDoneE2;
      selResult = MulResultE2;
    end else begin
      selStall  = {StallF1, StallD1, StallE1, FlushM1};
      selBusy   = BusyE1;
      selDone   = MulDoneE1;
      selResult = MulResultE1;
    end
  end

  // Number of RUN cycles the controller should spend on multiplier b.
  function automatic int unsigned expRuns(input logic [31:0] b, input int unsigned radix);
    int unsigned bits = 0;
    int unsigned et;
    for (int i = 0; i < 32; i++) if (b[i]) bits = i + 1;
    et = (bits == 0) ? 1 : (bits + radix - 1) / radix;
    return EARLY_TERM ? et : 32 / radix;
  endfunction

  task automatic runMul(input bit r2, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] acc, input logic mla, input logic [31:0] expv,
                        input bit holdStart, input string name);
    int unsigned runs = expRuns(b, r2 ? 2 : 1);
    @(negedge clk);
    useR2 = r2; SrcAE = a; SrcBE = b; AccE = acc; MlaE = mla;
    if (r2) StartE2 = 1'b1; else StartE1 = 1'b1;
    #1;
    checks++;
    if (selStall !== 4'hF || selBusy !== 1'b0 || selDone !== 1'b0) begin
      errors++;
      $display("FAIL %s start: stalls=%b busy=%b done=%b, want 1111/0/0", name, selStall, selBusy, selDone);
    end
    @(posedge clk); #1;
    if (!holdStart) begin StartE1 = 1'b0; StartE2 = 1'b0; end
    for (int i = 0; i < int'(runs); i++) begin
      @(negedge clk);
      checks++;
      if (selStall !== 4'hF || selBusy !== 1'b1 || selDone !== 1'b0) begin
        errors++;
        $display("FAIL %s run%0d: stalls=%b busy=%b done=%b, want 1111/1/0", name, i, selStall, selBusy, selDone);
      end
    end
    @(negedge clk);
    checks++;
    if (selDone !== 1'b1 || selResult !== expv || selStall !== 4'h0 || selBusy !== 1'b1) begin
      errors++;
      $display("FAIL %s done: done=%b result=%h stalls=%b busy=%b, want 1/%h/0000/1",
               name, selDone, selResult, selStall, selBusy, expv);
    end
    StartE1 = 1'b0; StartE2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({StallF1, StallD1, StallE1, FlushM1, BusyE1, MulDoneE1} !== 6'b0 || MulResultE1 !== 32'h0 ||
        {StallF2, StallD2, StallE2, FlushM2, BusyE2, MulDoneE2} !== 6'b0 || MulResultE2 !== 32'h0) begin
      errors++;
      $display("FAIL reset: r1 ctl=%b res=%h r2 ctl=%b res=%h, want 0",
               {StallF1, StallD1, StallE1, FlushM1, BusyE1, MulDoneE1}, MulResultE1,
               {StallF2, StallD2, StallE2, FlushM2, BusyE2, MulDoneE2}, MulResultE2);
    end
    reset = 1'b1;
  endtask

  task automatic test_mul_basic();
    runMul(1'b0, 32'd7, 32'd6, 32'hDEADBEEF, 1'b0, 32'd42, 1'b0, "mul7x6");
  endtask

  task automatic test_hold_result();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (selResult !== 32'd42 || selDone !== 1'b0 || selBusy !== 1'b0 || selStall !== 4'h0) begin
        errors++;
        $display("FAIL hold%0d: result=%h done=%b busy=%b stalls=%b, want 0000002a/0/0/0000",
                 i, selResult, selDone, selBusy, selStall);
      end
    end
  endtask

  task automatic test_mla_wrap();
    runMul(1'b0, 32'hFFFFFFFF, 32'd2, 32'd3, 1'b1, 32'h00000001, 1'b0, "mlaWrap");
  endtask

  task automatic test_radix2();
    runMul(1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h0, 1'b0, 32'h242D2080, 1'b0, "r2big");
    runMul(1'b1, 32'd5, 32'h0000000F, 32'h10, 1'b1, 32'd91, 1'b0, "r2digit3");
  endtask

  task automatic test_start_during_run();
    runMul(1'b0, 32'd9, 32'd9, 32'h0, 1'b0, 32'd81, 1'b1, "startHeld");
    @(negedge clk);
    checks++;
    if (selBusy !== 1'b0 || selResult !== 32'd81) begin
      errors++;
      $display("FAIL startHeldIdle: busy=%b result=%h, want 0/00000051", selBusy, selResult);
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    useR2 = 1'b0; SrcAE = 32'd3; SrcBE = 32'hFFFFFFFF; AccE = '0; MlaE = 1'b0; StartE1 = 1'b1;
    @(posedge clk); #1;
    StartE1 = 1'b0;
    repeat (9) @(negedge clk);
    @(negedge clk);
    checks++;
    if (BusyE1 !== 1'b1 || MulDoneE1 !== 1'b0) begin
      errors++;
      $display("FAIL midRunBusy: busy=%b done=%b, want 1/0", BusyE1, MulDoneE1);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({StallF1, StallD1, StallE1, FlushM1, BusyE1, MulDoneE1} !== 6'b0 || MulResultE1 !== 32'h0) begin
      errors++;
      $display("FAIL midRunReset: ctl=%b result=%h, want 000000/00000000",
               {StallF1, StallD1, StallE1, FlushM1, BusyE1, MulDoneE1}, MulResultE1);
    end
    reset = 1'b1;
    runMul(1'b0, 32'h10, 32'h10, 32'h0, 1'b0, 32'h100, 1'b0, "afterReset");
  endtask

  task automatic test_back_to_back();
    runMul(1'b0, 32'd3, 32'd4, 32'h0, 1'b0, 32'd12, 1'b0, "b2bFirst");
    runMul(1'b0, 32'd5, 32'd5, 32'h0, 1'b0, 32'd25, 1'b0, "b2bSecond");
  endtask

  task automatic test_early_term();
    runMul(1'b0, 32'd7, 32'd5, 32'h0, 1'b0, 32'd35, 1'b0, "et7x5");
    runMul(1'b0, 32'd123, 32'd0, 32'd9, 1'b1, 32'd9, 1'b0, "etZero");
    runMul(1'b1, 32'd11, 32'd5, 32'h0, 1'b0, 32'd55, 1'b0, "etR2");
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_hold_result();
    test_mla_wrap();
    test_radix2();
    test_start_during_run();
    test_reset_mid_run();
    test_back_to_back();
    test_early_term();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: time=%0t, want finish before 200000", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
